// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the two-master TestRam arbiter: FSM encoding and port ids.
package mem_bus_arbiter_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
    localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

    localparam logic PORT_0 = 1'b0;
    localparam logic PORT_1 = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_picker.sv
// Combinational winner select between the two masters (round-robin or fixed priority).
module mem_bus_arbiter_picker
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned PRIORITY_MODE = 0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid_c,
    output logic       grant_port_c
);

    always_comb begin
        grant_valid_c = |req;
        grant_port_c  = PORT_0;
        if (PRIORITY_MODE != 0) begin
            grant_port_c = req[0] ? PORT_0 : PORT_1;
        end else if (req == 2'b11) begin
            // Tie goes to whichever port was not served last.
            grant_port_c = ~last_grant;
        end else begin
            grant_port_c = req[1] ? PORT_1 : PORT_0;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one TestRam port between two bus masters; each access runs IDLE->ISSUE->WAIT->DONE
// and returns a one-cycle ack (optionally with err on timeout) to the winning master.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned PRIORITY_MODE = 0,
    parameter int unsigned TIMEOUT       = 15,
    parameter int unsigned TO_CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    input  logic              ram_data_ready
);

    localparam bit                  TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [ST_W-1:0]     state, state_nxt;
    logic                last_grant, last_grant_nxt;
    logic                cur_port, cur_port_nxt;
    logic [TO_CNT_W-1:0] to_cnt, to_cnt_nxt;

    logic                ram_we_nxt;
    logic [ADDR_W-1:0]   ram_addr_nxt;
    logic [DATA_W-1:0]   ram_data_in_nxt;
    logic                m0_ack_nxt, m0_err_nxt, m1_ack_nxt, m1_err_nxt;
    logic [DATA_W-1:0]   m0_rdata_nxt, m1_rdata_nxt;

    logic                grant_valid;
    logic                grant_port;

    mem_bus_arbiter_picker #(
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_picker (
        .req           ({m1_req, m0_req}),
        .last_grant    (last_grant),
        .grant_valid_c (grant_valid),
        .grant_port_c  (grant_port)
    );

    // Next-state and next-output logic; ack/err default low so they pulse for DONE only.
    always_comb begin
        state_nxt       = state;
        last_grant_nxt  = last_grant;
        cur_port_nxt    = cur_port;
        to_cnt_nxt      = to_cnt;
        ram_we_nxt      = ram_we;
        ram_addr_nxt    = ram_addr;
        ram_data_in_nxt = ram_data_in;
        m0_ack_nxt      = 1'b0;
        m0_err_nxt      = 1'b0;
        m1_ack_nxt      = 1'b0;
        m1_err_nxt      = 1'b0;
        m0_rdata_nxt    = m0_rdata;
        m1_rdata_nxt    = m1_rdata;

        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    cur_port_nxt = grant_port;
                    if (grant_port == PORT_1) begin
                        ram_we_nxt      = m1_wr;
                        ram_addr_nxt    = m1_addr;
                        ram_data_in_nxt = m1_wdata;
                    end else begin
                        ram_we_nxt      = m0_wr;
                        ram_addr_nxt    = m0_addr;
                        ram_data_in_nxt = m0_wdata;
                    end
                    state_nxt = ST_ISSUE;
                end
            end

            // data_ready may still reflect the previous address here, so it is not sampled.
            ST_ISSUE: begin
                to_cnt_nxt = '0;
                state_nxt  = ST_WAIT;
            end

            ST_WAIT: begin
                if (ram_data_ready) begin
                    ram_we_nxt = 1'b0;
                    state_nxt  = ST_DONE;
                    if (cur_port == PORT_1) begin
                        m1_ack_nxt = 1'b1;
                        if (!ram_we) m1_rdata_nxt = ram_data_out;
                    end else begin
                        m0_ack_nxt = 1'b1;
                        if (!ram_we) m0_rdata_nxt = ram_data_out;
                    end
                end else if (TO_EN && (to_cnt == TO_LAST)) begin
                    ram_we_nxt = 1'b0;
                    state_nxt  = ST_DONE;
                    if (cur_port == PORT_1) begin
                        m1_ack_nxt   = 1'b1;
                        m1_err_nxt   = 1'b1;
                        m1_rdata_nxt = '0;
                    end else begin
                        m0_ack_nxt   = 1'b1;
                        m0_err_nxt   = 1'b1;
                        m0_rdata_nxt = '0;
                    end
                end else begin
                    to_cnt_nxt = to_cnt + TO_CNT_W'(1);
                end
            end

            ST_DONE: begin
                last_grant_nxt = cur_port;
                state_nxt      = ST_IDLE;
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_grant  <= PORT_1;
            cur_port    <= PORT_0;
            to_cnt      <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            m0_ack      <= 1'b0;
            m0_err      <= 1'b0;
            m0_rdata    <= '0;
            m1_ack      <= 1'b0;
            m1_err      <= 1'b0;
            m1_rdata    <= '0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            cur_port    <= cur_port_nxt;
            to_cnt      <= to_cnt_nxt;
            ram_we      <= ram_we_nxt;
            ram_addr    <= ram_addr_nxt;
            ram_data_in <= ram_data_in_nxt;
            m0_ack      <= m0_ack_nxt;
            m0_err      <= m0_err_nxt;
            m0_rdata    <= m0_rdata_nxt;
            m1_ack      <= m1_ack_nxt;
            m1_err      <= m1_err_nxt;
            m1_rdata    <= m1_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: queued master transactions, expected acks in order.
module tb_mem_bus_arbiter;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    typedef struct {
        logic       port;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_v = '0;
    logic [1:0]  wr_v = '0;
    logic [15:0] addr_v [2];
    logic [7:0]  wdata_v [2];

    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [7:0]  m0_rdata, m1_rdata;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data_in, ram_data_out;
    logic        ram_data_ready;

    // fixed-priority instance with both masters always requesting
    logic        p_one = 1'b1;
    logic        p_zero = 1'b0;
    logic [15:0] p_a0 = 16'h0100;
    logic [15:0] p_a1 = 16'h0200;
    logic [7:0]  p_d = 8'h00;
    logic        p_m0_ack, p_m0_err, p_m1_ack, p_m1_err, p_ram_we;
    logic [7:0]  p_m0_rdata, p_m1_rdata, p_ram_din;
    logic [15:0] p_ram_addr;
    int          p0_acks = 0;
    int          p1_acks = 0;

    txn_t mq0[$];
    txn_t mq1[$];
    exp_t exp_q[$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   we_cycles = 0;
    int   flush_gen = 0;
    int   issue_cyc [2];
    int   last_ack_cyc [2];
    int   rdy_lat = 0;
    bit   rdy_tied0 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(req_v[0]), .m0_wr(wr_v[0]), .m0_addr(addr_v[0]), .m0_wdata(wdata_v[0]),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(req_v[1]), .m1_wr(wr_v[1]), .m1_addr(addr_v[1]), .m1_wdata(wdata_v[1]),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .ram_data_ready(ram_data_ready)
    );

    mem_bus_arbiter #(.PRIORITY_MODE(1)) dut_p (
        .clk(clk), .rst(rst),
        .m0_req(p_one), .m0_wr(p_zero), .m0_addr(p_a0), .m0_wdata(p_d),
        .m0_ack(p_m0_ack), .m0_err(p_m0_err), .m0_rdata(p_m0_rdata),
        .m1_req(p_one), .m1_wr(p_zero), .m1_addr(p_a1), .m1_wdata(p_d),
        .m1_ack(p_m1_ack), .m1_err(p_m1_err), .m1_rdata(p_m1_rdata),
        .ram_we(p_ram_we), .ram_addr(p_ram_addr), .ram_data_in(p_ram_din),
        .ram_data_out(p_d), .ram_data_ready(p_one)
    );

    always @(posedge clk) begin
        if (!rst) begin
            if (p_m0_ack) p0_acks <= p0_acks + 1;
            if (p_m1_ack) p1_acks <= p1_acks + 1;
        end
    end

    // RAM model: ready once the access signals have been stable for rdy_lat cycles
    logic [7:0]  mem [0:65535];
    bit          preloaded = 1'b0;
    logic [24:0] prev_sig = '0;
    int          stable_cnt = 0;
    logic [24:0] cur_sig;

    assign cur_sig        = {ram_we, ram_addr, ram_data_in};
    assign ram_data_out   = mem[ram_addr];
    assign ram_data_ready = !rdy_tied0 && (cur_sig == prev_sig) && (stable_cnt >= rdy_lat);

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
            mem[16'h0010] <= 8'h3C;
            mem[16'h0011] <= 8'h5A;
            mem[16'h0012] <= 8'hC3;
            mem[16'h0013] <= 8'h7E;
            mem[16'h0030] <= 8'h99;
            mem[16'h0031] <= 8'hE7;
            preloaded <= 1'b1;
        end else if (ram_we && ram_data_ready) begin
            mem[ram_addr] <= ram_data_in;
        end
        stable_cnt <= (cur_sig != prev_sig) ? 0 : stable_cnt + 1;
        prev_sig   <= cur_sig;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp_v);
        end
    endtask

    task automatic push_txn(input logic port, input logic wr, input logic [15:0] a,
                            input logic [7:0] d);
        txn_t t;
        t.wr = wr; t.addr = a; t.wdata = d;
        if (port) mq1.push_back(t);
        else      mq0.push_back(t);
    endtask

    task automatic push_exp(input logic port, input logic err, input logic [7:0] rd);
        exp_t x;
        x.port = port; x.err = err; x.rdata = rd;
        exp_q.push_back(x);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((mq0.size() != 0 || mq1.size() != 0 || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 300), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Master driver: present queue head, pop it on ack, hold req while work remains
    initial begin
        int seen_gen = 0;
        addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (flush_gen != seen_gen) begin
                mq0.delete();
                mq1.delete();
                seen_gen = flush_gen;
            end
            if (m0_ack && mq0.size() > 0) void'(mq0.pop_front());
            if (mq0.size() > 0) begin
                if (!req_v[0]) issue_cyc[0] = cyc;
                req_v[0] = 1'b1; wr_v[0] = mq0[0].wr;
                addr_v[0] = mq0[0].addr; wdata_v[0] = mq0[0].wdata;
            end else begin
                req_v[0] = 1'b0;
            end
            if (m1_ack && mq1.size() > 0) void'(mq1.pop_front());
            if (mq1.size() > 0) begin
                if (!req_v[1]) issue_cyc[1] = cyc;
                req_v[1] = 1'b1; wr_v[1] = mq1[0].wr;
                addr_v[1] = mq1[0].addr; wdata_v[1] = mq1[0].wdata;
            end else begin
                req_v[1] = 1'b0;
            end
        end
    end

    // Monitor: every ack is matched against the next expected response
    initial begin
        exp_t x;
        logic p;
        forever begin
            @(posedge clk);
            #1;
            if (ram_we) we_cycles++;
            if (m0_ack && m1_ack) begin
                checks++; errors++;
                $display("FAIL both_ack: actual=11 required=one-hot");
            end else if (m0_ack || m1_ack) begin
                p = m1_ack;
                last_ack_cyc[p] = cyc;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: port=%0d with empty scoreboard", p);
                end else begin
                    x = exp_q.pop_front();
                    check("ack{port,err,rdata}",
                          32'({p, p ? m1_err : m0_err, p ? m1_rdata : m0_rdata}),
                          32'({x.port, x.err, x.rdata}));
                end
            end
        end
    end

    initial begin
        int n;
        issue_cyc[0] = 0; issue_cyc[1] = 0; last_ack_cyc[0] = 0; last_ack_cyc[1] = 0;
        repeat (3) @(negedge clk);
        check("rst_ram_we",   32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_acks",     32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        check("rst_rdata",    32'({m0_rdata, m1_rdata}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single read, ready on second WAIT edge
        we_cycles = 0; rdy_lat = 1;
        push_txn(0, 0, 16'h0010, 8'h00); push_exp(0, 0, 8'h3C);
        wait_drain("drain_single");
        check("single_latency", 32'(last_ack_cyc[0] - issue_cyc[0]), 32'd4);
        check("single_no_we", 32'(we_cycles), 32'd0);

        // minimum latency, ready on first WAIT edge
        rdy_lat = 0;
        push_txn(1, 0, 16'h0012, 8'h00); push_exp(1, 0, 8'hC3);
        wait_drain("drain_minlat");
        check("min_latency", 32'(last_ack_cyc[1] - issue_cyc[1]), 32'd3);

        // write then read back; write ack keeps previous rdata
        rdy_lat = 1; we_cycles = 0;
        push_txn(1, 1, 16'h0020, 8'hA5); push_exp(1, 0, 8'hC3);
        push_txn(1, 0, 16'h0020, 8'h00); push_exp(1, 0, 8'hA5);
        wait_drain("drain_wr_rd");
        check("we_window", 32'(we_cycles), 32'd3);

        // contention, round-robin after port 1 was served last
        rdy_lat = 0;
        push_txn(0, 0, 16'h0010, 8'h00); push_txn(0, 0, 16'h0011, 8'h00);
        push_txn(1, 0, 16'h0012, 8'h00); push_txn(1, 0, 16'h0013, 8'h00);
        push_exp(0, 0, 8'h3C); push_exp(1, 0, 8'hC3);
        push_exp(0, 0, 8'h5A); push_exp(1, 0, 8'h7E);
        wait_drain("drain_contention");

        // timeout: ready never arrives
        rdy_tied0 = 1'b1;
        push_txn(0, 0, 16'h0030, 8'h00); push_exp(0, 1, 8'h00);
        wait_drain("drain_timeout");
        check("timeout_latency", 32'(last_ack_cyc[0] - issue_cyc[0]), 32'd17);

        // ready lands on the same edge as the timeout: data wins
        rdy_tied0 = 1'b0; rdy_lat = 14;
        push_txn(0, 0, 16'h0031, 8'h00); push_exp(0, 0, 8'hE7);
        wait_drain("drain_same_edge");
        check("same_edge_latency", 32'(last_ack_cyc[0] - issue_cyc[0]), 32'd17);

        // back-to-back from port 0 with req held
        rdy_lat = 0;
        push_txn(0, 0, 16'h0010, 8'h00); push_txn(0, 0, 16'h0011, 8'h00);
        push_exp(0, 0, 8'h3C); push_exp(0, 0, 8'h5A);
        wait_drain("drain_b2b");

        // reset during a stalled write
        rdy_tied0 = 1'b1;
        push_txn(1, 1, 16'h0040, 8'h11);
        n = 0;
        while (!ram_we && n < 50) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("rst_mid_we_before", 32'(ram_we), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        flush_gen++;
        #1;
        check("rst_mid_we_async", 32'(ram_we), 32'd0);
        check("rst_mid_no_ack", 32'({m0_ack, m1_ack}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rdy_tied0 = 1'b0; rdy_lat = 0;
        @(negedge clk);
        push_txn(0, 0, 16'h0012, 8'h00); push_txn(1, 0, 16'h0013, 8'h00);
        push_exp(0, 0, 8'hC3); push_exp(1, 0, 8'h7E);
        wait_drain("drain_after_rst");

        // fixed-priority instance
        check("prio_m1_starved", 32'(p1_acks), 32'd0);
        check("prio_m0_served", 32'(p0_acks >= 8), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
